// File: rtl/counter_sequencer.sv
// Bus-master sequencer for the pulse-counter register block: gate write, start, stop handshake, 8-byte readback.
// Optional gate-register readback check is enabled by defining COUNTER_SEQ_READBACK_EN.
module counter_sequencer #(
   parameter int DATA_WIDTH     = 8,
   parameter int CLK_HZ         = 50000000,
   parameter int RELEASE_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  res_n,
   input  logic                  cmd_start,
   input  logic [7:0]            gate_sec,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           result_count,
   output logic [31:0]           result_time,
   output logic                  timeout_err,
   output logic                  cfg_err,
   output logic [7:0]            addr,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  we,
   output logic                  start,
   input  logic                  stop
);

   localparam int SUB_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam int ASM_W = 8 * DATA_WIDTH;
   localparam logic [7:0] GATE_ADDR = 8'h27;

   typedef enum logic [3:0] {
      IDLE, WR, WR_HOLD, RB_ADDR, RB_WAIT, RB_CHK, ARM, WAIT_STOP,
      WAIT_RELEASE, RD_ADDR, RD_WAIT, RD_CAP, LOAD, ABORT
   } state_t;

   state_t           state;
   logic [7:0]       gate_lat;
   logic [2:0]       idx;
   logic [SUB_W-1:0] sub_cnt;
   logic [8:0]       sec_cnt;
   logic [REL_W-1:0] rel_cnt;
   logic [ASM_W-1:0] asm_q;
   logic [ASM_W-1:0] asm_next;
   logic [8:0]       sec_limit;

   // Result bytes arrive LSB first, so each new byte enters at the top.
   assign asm_next  = {rdata, asm_q[ASM_W-1:DATA_WIDTH]};
   assign sec_limit = {1'b0, gate_lat} + 9'd2;

`ifdef COUNTER_SEQ_READBACK_EN
   logic cfg_q;
   assign cfg_err = cfg_q;
`else
   assign cfg_err = 1'b0;
`endif

   function automatic logic [7:0] rom_addr(input logic [2:0] i);
      case (i)
         3'd0: rom_addr = 8'h28;
         3'd1: rom_addr = 8'h29;
         3'd2: rom_addr = 8'h30;
         3'd3: rom_addr = 8'h31;
         3'd4: rom_addr = 8'h32;
         3'd5: rom_addr = 8'h33;
         3'd6: rom_addr = 8'h34;
         3'd7: rom_addr = 8'h35;
      endcase
   endfunction

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         we           <= 1'b0;
         start        <= 1'b0;
         timeout_err  <= 1'b0;
`ifdef COUNTER_SEQ_READBACK_EN
         cfg_q        <= 1'b0;
`endif
         addr         <= 8'h00;
         wdata        <= '0;
         result_count <= '0;
         result_time  <= '0;
         gate_lat     <= '0;
         idx          <= '0;
         sub_cnt      <= '0;
         sec_cnt      <= '0;
         rel_cnt      <= '0;
         asm_q        <= '0;
      end else begin
         done  <= 1'b0;
         we    <= 1'b0;
         start <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_start) begin
                  gate_lat    <= gate_sec;
                  timeout_err <= 1'b0;
`ifdef COUNTER_SEQ_READBACK_EN
                  cfg_q       <= 1'b0;
`endif
                  busy        <= 1'b1;
                  addr        <= GATE_ADDR;
                  wdata       <= DATA_WIDTH'(gate_sec);
                  we          <= 1'b1;
                  state       <= WR;
               end
            end
            // The counter latches addr/wdata one cycle after we, so they stay put through WR_HOLD.
            WR: state <= WR_HOLD;
            WR_HOLD: begin
`ifdef COUNTER_SEQ_READBACK_EN
               addr  <= GATE_ADDR;
               state <= RB_ADDR;
`else
               start <= 1'b1;
               state <= ARM;
`endif
            end
`ifdef COUNTER_SEQ_READBACK_EN
            RB_ADDR: state <= RB_WAIT;
            RB_WAIT: state <= RB_CHK;
            RB_CHK: begin
               if (rdata != DATA_WIDTH'(gate_lat)) begin
                  cfg_q <= 1'b1;
                  done  <= 1'b1;
                  state <= ABORT;
               end else begin
                  start <= 1'b1;
                  state <= ARM;
               end
            end
`endif
            ARM: begin
               sub_cnt <= '0;
               sec_cnt <= '0;
               state   <= WAIT_STOP;
            end
            WAIT_STOP: begin
               if (stop) begin
                  sub_cnt <= '0;
                  sec_cnt <= '0;
                  rel_cnt <= '0;
                  state   <= WAIT_RELEASE;
               end else if (sec_cnt == sec_limit) begin
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  state       <= ABORT;
               end else if (sub_cnt == SUB_W'(CLK_HZ - 1)) begin
                  sub_cnt <= '0;
                  sec_cnt <= sec_cnt + 9'd1;
               end else begin
                  sub_cnt <= sub_cnt + SUB_W'(1);
               end
            end
            WAIT_RELEASE: begin
               if (!stop) begin
                  idx   <= '0;
                  state <= RD_ADDR;
               end else if (rel_cnt == REL_W'(RELEASE_CYCLES - 1)) begin
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  state       <= ABORT;
               end else begin
                  rel_cnt <= rel_cnt + REL_W'(1);
               end
            end
            // rdata is registered in the counter: address out, one wait cycle, then capture.
            RD_ADDR: begin
               addr  <= rom_addr(idx);
               state <= RD_WAIT;
            end
            RD_WAIT: state <= RD_CAP;
            RD_CAP: begin
               asm_q <= asm_next;
               if (idx == 3'd7) begin
                  result_count <= 32'(asm_next[4*DATA_WIDTH-1:0]);
                  result_time  <= 32'(asm_next[ASM_W-1:4*DATA_WIDTH]);
                  done         <= 1'b1;
                  state        <= LOAD;
               end else begin
                  idx   <= idx + 3'd1;
                  state <= RD_ADDR;
               end
            end
            // done is high during LOAD/ABORT; busy drops with it on the way back to IDLE.
            LOAD, ABORT: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer with a behavioural pulse-counter register model.
module tb_counter_sequencer;

   localparam int CLK_HZ  = 1000;
   localparam int REL_CYC = 1000;

   logic        clk = 1'b0;
   logic        res_n = 1'b0;
   logic        cmd_start = 1'b0;
   logic [7:0]  gate_sec = 8'h00;
   logic        busy, done, timeout_err, cfg_err, we, start;
   logic [31:0] result_count, result_time;
   logic [7:0]  addr, wdata;
   logic [7:0]  rdata = 8'h00;
   logic        stop = 1'b0;

   int total = 0;
   int bad = 0;

   counter_sequencer #(.DATA_WIDTH(8), .CLK_HZ(CLK_HZ), .RELEASE_CYCLES(REL_CYC)) dut (
      .clk(clk), .res_n(res_n), .cmd_start(cmd_start), .gate_sec(gate_sec),
      .busy(busy), .done(done), .result_count(result_count), .result_time(result_time),
      .timeout_err(timeout_err), .cfg_err(cfg_err), .addr(addr), .wdata(wdata),
      .rdata(rdata), .we(we), .start(start), .stop(stop)
   );

   always #5 clk = ~clk;

   logic [7:0] rd_map [8] = '{8'h28, 8'h29, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

   // Counter model: gate register, 8 result bytes, stop high 200 cycles after a 50-cycle delay.
   logic [31:0] m_count = 32'h0;
   logic [31:0] m_time = 32'h0;
   logic        corrupt = 1'b0;
   logic        never_stop = 1'b0;
   logic [7:0]  mem27 = 8'h00;
   logic        we_d = 1'b0;
   int          m_cnt = 0;
   wire  [63:0] m_bytes = {m_time, m_count};

   always @(posedge clk) begin
      we_d <= we;
      if (we_d && addr == 8'h27) mem27 <= corrupt ? 8'h05 : wdata;
      rdata <= 8'h00;
      if (addr == 8'h27) rdata <= mem27;
      for (int i = 0; i < 8; i++)
         if (addr == rd_map[i]) rdata <= m_bytes[8*i +: 8];
      if (m_cnt != 0) m_cnt <= (m_cnt == 260) ? 0 : m_cnt + 1;
      else if (start && !never_stop) m_cnt <= 1;
      stop <= (m_cnt >= 50) && (m_cnt < 250);
   end

   // Bus monitor: per-run pulse counts and the sequence of distinct addresses.
   logic [7:0] log_a [16];
   int         log_n = 0;
   int         run_we = 0, run_start = 0, run_ovl = 0;
   logic [7:0] we_addr = 8'h00, we_data = 8'h00;
   int         cyc = 0, start_cyc = 0, done_cyc = 0;
   logic       busy_q = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (busy && !busy_q) begin
            log_n = 0; run_we = 0; run_start = 0; run_ovl = 0;
         end
         if (busy && log_n < 16 && (log_n == 0 || addr != log_a[log_n-1])) begin
            log_a[log_n] = addr;
            log_n++;
         end
         if (we) begin run_we++; we_addr = addr; we_data = wdata; end
         if (start) begin run_start++; start_cyc = cyc; end
         if (we && start) run_ovl++;
         if (done) done_cyc = cyc;
         busy_q = busy;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 10000 && !ok; i++) begin
         if (done) ok = 1'b1;
         else @(negedge clk);
      end
      chk("done_seen", ok, 1);
   endtask

   task automatic launch(input logic [7:0] g);
      @(negedge clk);
      gate_sec  = g;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   task automatic check_success(input logic [7:0] g, input logic [31:0] c, input logic [31:0] t);
      chk("result_count", result_count, c);
      chk("result_time", result_time, t);
      chk("timeout_err", timeout_err, 0);
      chk("cfg_err", cfg_err, 0);
      chk("busy_at_done", busy, 1);
      chk("we_pulses", run_we, 1);
      chk("we_addr", we_addr, 8'h27);
      chk("we_data", we_data, g);
      chk("start_pulses", run_start, 1);
      chk("we_start_overlap", run_ovl, 0);
      chk("addr_seq_len", log_n, 9);
      chk("addr_seq_gate", log_a[0], 8'h27);
      for (int i = 0; i < 8; i++) chk("addr_seq_read", log_a[i+1], rd_map[i]);
      @(negedge clk);
      chk("done_width", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", we, 0);
      chk("rst_start", start, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_addr", addr, 8'h00);
      chk("rst_wdata", wdata, 8'h00);
      chk("rst_result_count", result_count, 0);
      chk("rst_result_time", result_time, 0);
   endtask

   initial begin
      logic [31:0] pc, pt;
      logic [7:0]  g;
      logic        ok;

      repeat (3) @(negedge clk);
      check_reset_outputs();
      res_n = 1'b1;

      // Directed run from the register-map example.
      m_count = 32'h12345678;
      m_time  = 32'd3050;
      launch(8'd3);
      wait_done();
      check_success(8'd3, 32'h12345678, 32'h00000BEA);

      // Randomized runs.
      for (int r = 0; r < 3; r++) begin
         m_count = $urandom;
         m_time  = $urandom;
         g = 8'($urandom_range(0, 3));
         launch(g);
         wait_done();
         check_success(g, m_count, m_time);
      end

      // Stop never rises: watchdog expires after gate+2 seconds, results untouched.
      pc = m_count; pt = m_time;
      never_stop = 1'b1;
      m_count = $urandom;
      launch(8'd2);
      wait_done();
      chk("to_timeout_err", timeout_err, 1);
      chk("to_busy_at_done", busy, 1);
      chk("to_result_count", result_count, pc);
      chk("to_result_time", result_time, pt);
      chk("to_cfg_err", cfg_err, 0);
      @(negedge clk);
      chk("to_done_width", done, 0);
      chk("to_delay_window", (done_cyc - start_cyc >= 4*CLK_HZ) && (done_cyc - start_cyc <= 4*CLK_HZ + 4), 1);
      repeat (5) @(negedge clk);
      chk("to_sticky", timeout_err, 1);
      never_stop = 1'b0;

      // cmd_start held through a whole run, then a gate_sec=0 run.
      m_count = $urandom;
      m_time  = $urandom;
      gate_sec  = 8'd1;
      cmd_start = 1'b1;
      @(negedge clk);
      wait_done();
      check_success(8'd1, m_count, m_time);
      gate_sec = 8'd0;
      m_count  = $urandom_range(0, 3);
      m_time   = $urandom_range(0, 60);
      @(negedge clk);
      cmd_start = 1'b0;
      chk("held_reaccept_busy", busy, 1);
      wait_done();
      check_success(8'd0, m_count, m_time);

      // Asynchronous reset while waiting for stop.
      m_count = $urandom;
      launch(8'd3);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (run_start != 0) ok = 1'b1;
         else @(negedge clk);
      end
      chk("mid_start_seen", ok, 1);
      repeat (20) @(negedge clk);
      #2 res_n = 1'b0;
      #1 check_reset_outputs();
      @(negedge clk);
      res_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         if (m_cnt == 0 && !stop) ok = 1'b1;
      end
      chk("mid_model_idle", ok, 1);
      m_count = $urandom;
      m_time  = $urandom;
      launch(8'd1);
      wait_done();
      check_success(8'd1, m_count, m_time);

`ifdef COUNTER_SEQ_READBACK_EN
      // Gate write lands corrupted: readback must abort before start.
      pc = m_count; pt = m_time;
      corrupt = 1'b1;
      m_count = $urandom;
      launch(8'd4);
      wait_done();
      chk("rb_cfg_err", cfg_err, 1);
      chk("rb_timeout_err", timeout_err, 0);
      chk("rb_no_start", run_start, 0);
      chk("rb_result_count", result_count, pc);
      chk("rb_result_time", result_time, pt);
      @(negedge clk);
      chk("rb_done_width", done, 0);
      chk("rb_busy_after", busy, 0);
      corrupt = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
